// File: rtl/dmem_responder_if.sv
// Request/response bundle between the datapath memory port and the data-memory responder.
// Latency: none, wires only.
// Backpressure: req_ready gates requests; rsp_valid is a single-cycle pulse the master must take.
//
// Signals:
//   req_valid/req_ready : request handshake (master -> slave, ready from slave)
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata           : store data
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata           : load data, 0 for stores
//   rsp_err             : misaligned-access flag, valid with rsp_valid
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory answering load/store requests with fixed wait states.
// Latency: response pulse in the (WAIT+2)th cycle after the accept edge; one request per WAIT+3 cycles.
// Backpressure: req_ready only in IDLE; the response has no backpressure and lasts exactly one cycle.
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset (FSM and response state only; memory array is not cleared)
//   bus  : dmem_responder_if.slave request/response channel
// Parameters: DEPTH_LOG2 (log2 words), WAIT (wait states, 0..15).
// Optional macro DMEM_ERR_EN: flag misaligned accesses (addr[1:0] != 0) with rsp_err, suppress
// the store and return 0 for the load. Without it addr[1:0] is ignored and rsp_err is tied 0.
module dmem_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int WAIT       = 2
) (
   input  logic            clk,
   input  logic            rst,
   dmem_responder_if.slave bus
);

   localparam int         DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, ACCESS, WAITS, RESP} state_t;

   // Only the address bits that select a word (plus the alignment bits) are kept;
   // higher bits alias by construction.
   typedef struct packed {
      logic                  we;
      logic [DEPTH_LOG2+1:0] addr;
      logic [31:0]           wdata;
   } req_t;

   state_t                state;
   state_t                state_nxt;
   req_t                  req_q;
   logic [3:0]            wait_cnt;
   logic [31:0]           rdata_q;
   logic                  err_q;
   logic [31:0]           mem [DEPTH];
   logic                  accept;
   logic                  misaligned;
   logic [DEPTH_LOG2-1:0] word_idx;

   assign word_idx = req_q.addr[DEPTH_LOG2+1:2];

`ifdef DMEM_ERR_EN
   assign misaligned = |req_q.addr[1:0];
`else
   assign misaligned = 1'b0;
`endif

   assign accept        = bus.req_valid && bus.req_ready;
   assign bus.rsp_rdata = rdata_q;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ACCESS;
         ACCESS:  state_nxt = (WAIT > 0) ? WAITS : RESP;
         WAITS:   if (wait_cnt == 4'd0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs. req_ready is masked by rst so the requester sees "not ready" while held in reset.
   always_comb begin
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_err   = 1'b0;
      case (state)
         IDLE: bus.req_ready = rst;
         RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = err_q;
         end
         default: ;
      endcase
   end

   // Request latch, wait counter and response registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q    <= '0;
         wait_cnt <= 4'd0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            req_q <= '{we:    bus.req_we,
                       addr:  bus.req_addr[DEPTH_LOG2+1:0],
                       wdata: bus.req_wdata};
         end
         if (state == ACCESS) begin
            wait_cnt <= WAIT_LOAD;
            err_q    <= misaligned;
            rdata_q  <= (req_q.we || misaligned) ? 32'd0 : mem[word_idx];
         end else if (state == WAITS && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
      end
   end

   // Storage array has no reset. A reset before the ACCESS exit edge forces IDLE
   // asynchronously, so the pending store is dropped.
   always_ff @(posedge clk) begin
      if (state == ACCESS && req_q.we && !misaligned) begin
         mem[word_idx] <= req_q.wdata;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int DEPTH_LOG2 = 10;
   localparam int WAIT       = 2;
   localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef DMEM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;

   dmem_responder_if bus ();

   dmem_responder #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WAIT       (WAIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Reference model: memory as an array of words indexed by (byte address / 4) mod depth.
   logic [31:0] ref_mem   [DEPTH];
   bit          ref_known [DEPTH];

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request in an IDLE cycle and return just after the accept edge.
   // Afterwards the request lines carry junk, which the responder must ignore.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag);
      int w;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      w = 0;
      while (bus.req_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      check({tag, " ready_at_issue"}, 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
   endtask

   // Full transaction checked against the model.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input string tag);
      bit          mis;
      logic [31:0] exp_rd;
      int          lat;
      bit          seen;
      int          busy_bad;
      logic [31:0] got_rd;
      logic        got_err;
      mis    = ERR_EN && (addr[1:0] != 2'b00);
      exp_rd = (we || mis) ? 32'h0 : ref_mem[widx(addr)];
      issue(we, addr, wdata, tag);
      seen     = 1'b0;
      lat      = -1;
      busy_bad = 0;
      got_rd   = 'x;
      got_err  = 1'bx;
      for (int k = 1; k <= WAIT + 20 && !seen; k++) begin
         @(negedge clk);
         if (bus.req_ready !== 1'b0) busy_bad++;
         if (bus.rsp_valid === 1'b1) begin
            seen    = 1'b1;
            lat     = k;
            got_rd  = bus.rsp_rdata;
            got_err = bus.rsp_err;
         end
      end
      check({tag, " latency"}, 32'(lat), 32'(WAIT + 2));
      if (we || mis || ref_known[widx(addr)]) check({tag, " rdata"}, got_rd, exp_rd);
      check({tag, " err"}, 32'(got_err), 32'(mis));
      check({tag, " ready_low_busy"}, 32'(busy_bad), 32'd0);
      @(negedge clk);
      check({tag, " pulse_one_cycle"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, " ready_after"}, 32'(bus.req_ready), 32'd1);
      if (we && !mis) begin
         ref_mem[widx(addr)]   = wdata;
         ref_known[widx(addr)] = 1'b1;
      end
   endtask

   // Reset asserted hit_k cycles after the accept edge of a store of 0xCAFE to 0x40.
   // The store survives only if its ACCESS exit edge (first edge after accept) has passed.
   task automatic reset_during_store(input int hit_k, input string tag);
      int bad;
      int stale;
      access(1'b1, 32'h40, 32'h1234, {tag, " prior"});
      issue(1'b1, 32'h40, 32'hCAFE, tag);
      repeat (hit_k) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.req_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      check({tag, " outputs_in_reset"}, 32'(bad), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check({tag, " ready_after_reset"}, 32'(bus.req_ready), 32'd1);
      stale = 0;
      for (int k = 0; k < WAIT + 4; k++) begin
         if (bus.rsp_valid !== 1'b0) stale++;
         @(negedge clk);
      end
      check({tag, " no_stale_rsp"}, 32'(stale), 32'd0);
      if (hit_k >= 2) ref_mem[widx(32'h40)] = 32'hCAFE;
      access(1'b0, 32'h40, 32'h0, {tag, " load"});
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          acc_cyc [3];
      int          n_acc;
      int          t;
      int          word;
      logic [31:0] addr;
      logic [1:0]  low;

      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

      // Reset state
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset req_ready", 32'(bus.req_ready), 32'd0);
      check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
      check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("release req_ready", 32'(bus.req_ready), 32'd1);

      // Basic store/load
      access(1'b1, 32'h10, 32'hDEADBEEF, "st_beef");
      access(1'b0, 32'h10, 32'h0, "ld_beef");
      check("ld_beef const", bus.rsp_rdata, 32'hDEADBEEF);

      // Aliasing through ignored high address bits
      access(1'b1, 32'h4, 32'h11, "st_alias");
      access(1'b0, 32'h1004, 32'h0, "ld_alias");
      check("ld_alias const", bus.rsp_rdata, 32'h11);

      // Misaligned store, then aligned load of the same word
      access(1'b1, 32'h20, 32'h77, "st_pre");
      access(1'b1, 32'h22, 32'h5, "st_mis");
      access(1'b0, 32'h20, 32'h0, "ld_mis");
      check("ld_mis const", bus.rsp_rdata, ERR_EN ? 32'h77 : 32'h5);

      // Back-to-back: req_valid held high for three loads
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 32'h10;
      n_acc = 0;
      t     = 0;
      while (n_acc < 3 && t < 60) begin
         if (bus.req_ready === 1'b1) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
         end
         @(negedge clk);
         t++;
      end
      bus.req_valid = 1'b0;
      check("b2b accepts", 32'(n_acc), 32'd3);
      if (n_acc == 3) begin
         check("b2b gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(WAIT + 3));
         check("b2b gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(WAIT + 3));
      end
      repeat (WAIT + 4) @(negedge clk);

      // Reset in the middle of a store
      reset_during_store(2, "rst_waits");
      reset_during_store(1, "rst_access");

      // Randomized traffic over a pool of words, with random alias bits and alignment
      for (int p = 0; p < 16; p++) begin
         word = (p * 37 + 3) % DEPTH;
         access(1'b1, 32'(word) << 2, $urandom, "rnd_init");
      end
      for (int n = 0; n < 40; n++) begin
         word = (int'($urandom_range(0, 15)) * 37 + 3) % DEPTH;
         low  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         addr = ($urandom & ~32'((DEPTH << 2) - 1)) | (32'(word) << 2) | 32'(low);
         access(1'($urandom_range(0, 1)), addr, $urandom, "rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
